// File: rtl/exponentiation.sv
// -----------------------------------------------------------------------------
// exponentiation
//   Sequential integer power unit: resultado = X^Y (X^0 = 1, including 0^0).
//   Each multiply acc*X runs as an 8-cycle shift-and-add over the latched X,
//   so a full run takes 8*Y+1 cycles after the accepting start edge.
//
// Ports
//   clock      in   1    rising-edge clock
//   reset      in   1    synchronous active-high reset
//   start      in   1    request strobe, accepted in IDLE or DONE
//   X          in   8    unsigned base, captured on the accepting edge
//   Y          in   4    unsigned exponent, captured on the accepting edge
//   end_expo   out  1    registered done flag, held high while in DONE
//   resultado  out  128  registered result, updated only on completion
// -----------------------------------------------------------------------------
module exponentiation (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [7:0]   X,
   input  logic [3:0]   Y,
   output logic         end_expo,
   output logic [127:0] resultado
);

   typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

   state_t         state_q, state_d;
   logic [7:0]     x_q, x_d;
   logic [127:0]   acc_q, acc_d;
   logic [127:0]   pp_q, pp_d;
   logic [2:0]     bit_q, bit_d;
   logic [3:0]     cnt_q, cnt_d;
   logic           end_q, end_d;
   logic [127:0]   res_q, res_d;
   logic [127:0]   pp_sum;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         acc_q   <= '0;
         pp_q    <= '0;
         bit_q   <= '0;
         cnt_q   <= '0;
         end_q   <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         acc_q   <= acc_d;
         pp_q    <= pp_d;
         bit_q   <= bit_d;
         cnt_q   <= cnt_d;
         end_q   <= end_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      acc_d   = acc_q;
      pp_d    = pp_q;
      bit_d   = bit_q;
      cnt_d   = cnt_q;
      end_d   = end_q;
      res_d   = res_q;

      // Partial product after folding in multiplier bit bit_q.
      pp_sum  = pp_q + (x_q[bit_q] ? (acc_q << bit_q) : '0);

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               x_d     = X;
               acc_d   = 128'd1;
               pp_d    = '0;
               bit_d   = '0;
               cnt_d   = Y;
               end_d   = 1'b0;
               state_d = MULT;
            end
         end
         MULT: begin
            if (cnt_q == 4'd0) begin
               res_d   = acc_q;
               end_d   = 1'b1;
               state_d = DONE;
            end else if (bit_q == 3'd7) begin
               // Last bit: the sum including bit 7 is the finished product.
               acc_d   = pp_sum;
               pp_d    = '0;
               bit_d   = '0;
               cnt_d   = cnt_q - 4'd1;
            end else begin
               pp_d    = pp_sum;
               bit_d   = bit_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign end_expo  = end_q;
   assign resultado = res_q;

endmodule

// File: tb/tb_exponentiation.sv
module tb_exponentiation;

   logic         clock;
   logic         reset;
   logic         start;
   logic [7:0]   X;
   logic [3:0]   Y;
   logic         end_expo;
   logic [127:0] resultado;

   int unsigned  n_tests;
   int unsigned  n_fail;
   logic [127:0] prev_res;

   exponentiation dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .X         (X),
      .Y         (Y),
      .end_expo  (end_expo),
      .resultado (resultado)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] pow_ref(input logic [7:0] x, input logic [3:0] y);
      logic [127:0] r;
      r = 128'd1;
      for (int i = 0; i < int'(y); i++) r = r * {120'd0, x};
      return r;
   endfunction

   // Start one computation, optionally jabbing start with junk operands while
   // busy, then check latency, result and that resultado never moved early.
   task automatic run(input logic [7:0] x, input logic [3:0] y,
                      input logic [127:0] exp, input bit noise);
      int unsigned n;
      int unsigned lat;
      @(negedge clock);
      start = 1'b1; X = x; Y = y;
      @(posedge clock);
      #1;
      start = 1'b0; X = 8'($urandom); Y = 4'($urandom);
      check("end_falls_at_E0", {127'd0, end_expo}, 128'd0);
      check("res_held_at_E0", resultado, prev_res);
      n = 0;
      lat = (y == 4'd0) ? 1 : 8 * int'(y) + 1;
      while (n < 200) begin
         start = noise && ($urandom_range(0, 3) == 0);
         X = 8'($urandom); Y = 4'($urandom);
         @(posedge clock);
         n++;
         #1;
         if (end_expo) break;
         if (n == lat / 2) check("res_stable_busy", resultado, prev_res);
      end
      start = 1'b0;
      check("latency", 128'(n), 128'(lat));
      check("result", resultado, exp);
      prev_res = resultado;
   endtask

   initial begin
      logic [127:0] big;
      n_tests = 0; n_fail = 0; prev_res = '0;
      reset = 1'b1; start = 1'b0; X = '0; Y = '0;
      repeat (2) @(posedge clock);
      #1;
      check("reset_end", {127'd0, end_expo}, 128'd0);
      check("reset_res", resultado, 128'd0);
      @(negedge clock); reset = 1'b0;

      run(8'd3, 4'd4, 128'd81, 1'b0);
      repeat (5) @(negedge clock);
      check("done_hold_end", {127'd0, end_expo}, 128'd1);
      check("done_hold_res", resultado, 128'd81);

      run(8'd0, 4'd0, 128'd1, 1'b0);
      run(8'd0, 4'd5, 128'd0, 1'b0);

      big = pow_ref(8'd255, 4'd15);
      run(8'd255, 4'd15, big, 1'b0);
      check("max_top_zero", {120'd0, resultado[127:120]}, 128'd0);
      check("max_high_nonzero", {127'd0, (resultado[119:113] != 7'd0)}, 128'd1);

      run(8'd2, 4'd15, 128'd32768, 1'b0);
      run(8'd255, 4'd2, 128'd65025, 1'b0);

      // Abort mid-computation with reset.
      @(negedge clock);
      start = 1'b1; X = 8'd7; Y = 4'd9;
      @(negedge clock);
      start = 1'b0;
      repeat (20) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("abort_end", {127'd0, end_expo}, 128'd0);
      check("abort_res", resultado, 128'd0);
      repeat (80) @(negedge clock);
      check("abort_no_done", {127'd0, end_expo}, 128'd0);
      check("abort_res_late", resultado, 128'd0);
      prev_res = '0;
      run(8'd7, 4'd2, 128'd49, 1'b0);

      for (int k = 0; k < 100; k++) begin
         logic [7:0] rx;
         logic [3:0] ry;
         rx = 8'($urandom_range(0, 255));
         ry = 4'($urandom_range(0, 15));
         run(rx, ry, pow_ref(rx, ry), 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/exponentiation.md
EXPONENTIATION -- requirements
Module: exponentiation

Interface
REQ-001 The block SHALL have exactly one clock and one synchronous, active-high reset; it SHALL have no parameters.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset, sampled on the rising clock edge.
REQ-004 start  input  1  request strobe; sampled each rising edge; one cycle wide is sufficient.
REQ-005 X  input  8  unsigned base.
REQ-006 Y  input  4  unsigned exponent, 0..15.
REQ-007 end_expo  output  1  registered done flag.
REQ-008 resultado  output  128  registered unsigned result X^Y.

Function
REQ-009 The block SHALL compute resultado = X^Y exactly, with X^0 = 1 for every X, including 0^0 = 1.
REQ-010 The 128-bit width SHALL hold every result without overflow, because the maximum 255^15 is below 2^120.
REQ-011 The block SHALL have three states: IDLE, MULT and DONE.
REQ-012 In IDLE or DONE, start=1 at edge E0 SHALL:
- latch X and Y into internal registers;
- set the accumulator to 1, clear the partial product, and clear the bit index;
- load the remaining count with Y;
- clear end_expo;
- enter MULT.
REQ-013 X and Y SHALL be ignored after E0 until the next accepted start.
REQ-014 MULT SHALL compute acc*X by sequential shift-and-add, one multiplier bit per cycle. On each edge it SHALL add (acc << i) to the partial product when latched X bit i is 1, then increment i.
REQ-015 After bit 7 is processed, the block SHALL write the completed product into acc, clear the partial product and bit index, and decrement the remaining count. Each multiplication SHALL therefore take exactly 8 cycles.
REQ-016 In MULT with remaining count 0, the next edge SHALL set resultado to acc, set end_expo to 1, and enter DONE.
REQ-017 Latency: end_expo SHALL rise at edge E0+1 when Y=0, and at edge E0+8*Y+1 when Y>0.
- Worst case is Y=15: 121 cycles.
REQ-018 In DONE, end_expo SHALL stay at 1 and resultado SHALL stay stable until the next accepted start or reset.
REQ-019 On an accepted start from DONE, end_expo SHALL fall at E0; resultado SHALL keep its old value until the next completion.
REQ-020 start asserted while in MULT SHALL be ignored and SHALL NOT restart or corrupt the computation.
REQ-021 resultado SHALL change only on completion edges and on reset; it SHALL never show intermediate accumulator values.
REQ-022 Internal multiply datapath widths SHALL be at least 128 bits; truncation is unreachable for legal inputs.

Reset
REQ-023 When reset=1 at a rising edge, the block SHALL enter IDLE and clear end_expo, resultado, the accumulator, the partial product, the counters and the latched operands.
REQ-024 Reset SHALL take priority over start.
REQ-025 Reset during MULT SHALL abort the computation: no done pulse and no result update.
REQ-026 After reset deasserts, the first start SHALL be accepted normally.

Verification
REQ-027 Scenario: reset, then start with X=3, Y=4 -> end_expo rises at E0+33 and resultado=81.
REQ-028 Scenario: start with X=0, Y=0 -> end_expo rises at E0+1 and resultado=1; start with X=0, Y=5 -> resultado=0.
REQ-029 Scenario: start with X=255, Y=15 -> end_expo rises at E0+121 and resultado equals the bench reference model 255^15 (nonzero above bit 112, zero in bits 127..120).
REQ-030 Scenario: X=2, Y=15 -> resultado=32768; then start with X=255, Y=2 -> end_expo falls at E0, then resultado=65025.
REQ-031 Scenario: reset asserted mid-MULT for X=7, Y=9 -> end_expo=0 and resultado=0; a subsequent start with X=7, Y=2 -> resultado=49.
REQ-032 Scenario: 100 random starts (X 0..255, Y 0..15), each waiting for end_expo -> every resultado matches the reference model, and start pulses during MULT have no effect.
